// File: rtl/uart_tx_serializer.sv
// 8E2 UART transmitter: start, 8 data bits LSB first, even parity, two stops.
// Define UART_TX_FIFO_EN for an input FIFO that allows back-to-back frames.
module uart_tx_serializer #(
  parameter int INPUT_CLOCK = 50000000,
  parameter int UART_BAUD   = 9600
`ifdef UART_TX_FIFO_EN
  ,
  parameter int FIFO_DEPTH  = 4
`endif
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CBB = INPUT_CLOCK / UART_BAUD;
  localparam int CW  = $clog2(CBB + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    data_r, data_n;
  logic          tx_n;
  logic          bit_done;
  logic          load;
  logic [7:0]    load_data;

  assign bit_done = (cnt == CW'(CBB - 1));

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign data_ready = !full && !rst;
  assign push       = data_valid && data_ready;
  // Popping at the end of STOP2 chains frames with no idle bit.
  assign pop        = !empty &&
                      ((state == IDLE) ||
                       ((state == STOP2) && bit_done));
  assign load       = pop;
  assign load_data  = mem[rptr];

  always_ff @(posedge clk50MHz) begin
    if (push) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  assign data_ready = (state == IDLE) && !rst;
  assign load       = data_valid && data_ready;
  assign load_data  = data_in;
`endif

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      data_r <= '0;
      tx     <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      data_r <= data_n;
      tx     <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = data_r;
    cnt_n   = '0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_n = START;
          data_n  = load_data;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == 3'd7) state_n = PARITY;
          else             idx_n   = idx + 1'b1;
        end
      end
      PARITY: if (bit_done) state_n = STOP1;
      STOP1:  if (bit_done) state_n = STOP2;
      STOP2: begin
        if (bit_done) begin
          if (load) begin
            state_n = START;
            data_n  = load_data;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if ((state != IDLE) && !bit_done) cnt_n = cnt + 1'b1;
  end

  // tx is registered from the next state so it moves on the loading edge.
  always_comb begin
    tx_n = 1'b1;
    busy = (state != IDLE);
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[idx_n];
      PARITY:  tx_n = ^data_n;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a shortened bit time.
// Frame contents and timing are checked every cycle.
module tb_uart_tx_serializer;

  localparam int CBB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;

  int npass = 0;
  int ntot  = 0;

  uart_tx_serializer #(
    .INPUT_CLOCK(CBB * 10),
    .UART_BAUD  (10)
  ) dut (
    .clk50MHz  (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    data_in    = 8'hxx;
`ifdef UART_TX_FIFO_EN
    step();
`endif
  endtask

  // Called #1 after the frame's first edge, or skip cycles later.
  task automatic check_frame(input logic [7:0] b, input int skip);
    logic [11:0] bits;
    bits[0]     = 1'b0;
    bits[8:1]   = b;
    bits[9]     = ^b;
    bits[11:10] = 2'b11;
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < CBB; c++) begin
        if (i * CBB + c >= skip) begin
          chk($sformatf("tx_%h_b%0d_c%0d", b, i, c), {7'd0, tx},
              {7'd0, bits[i]});
          chk($sformatf("busy_%h_b%0d", b, i), {7'd0, busy}, 8'd1);
`ifndef UART_TX_FIFO_EN
          chk($sformatf("rdy_%h_b%0d", b, i), {7'd0, data_ready}, 8'd0);
`endif
          step();
        end
      end
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tx"},   {7'd0, tx},         8'd1);
    chk({tag, "_busy"}, {7'd0, busy},       8'd0);
    chk({tag, "_rdy"},  {7'd0, data_ready}, 8'd1);
  endtask

  initial begin
    rst        = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    step();
    step();
    chk("rst_tx",   {7'd0, tx},         8'd1);
    chk("rst_busy", {7'd0, busy},       8'd0);
    chk("rst_rdy",  {7'd0, data_ready}, 8'd0);
    rst = 1'b0;
    step();
    check_idle("post_rst");

    push_byte(8'h2D);
    check_frame(8'h2D, 0);
    check_idle("after_2d");

    push_byte(8'h01);
    check_frame(8'h01, 0);
    check_idle("after_01");
    push_byte(8'hFF);
    check_frame(8'hFF, 0);
    check_idle("after_ff");

`ifdef UART_TX_FIFO_EN
    begin
      logic [7:0] vec [6];
      logic [5:0] rdy_exp;
      vec     = '{8'h55, 8'hAA, 8'h00, 8'h80, 8'h7E, 8'h11};
      rdy_exp = 6'b011111;
      data_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
        data_in = vec[k];
        chk($sformatf("fifo_rdy_%0d", k), {7'd0, data_ready},
            {7'd0, rdy_exp[k]});
        step();
      end
      data_valid = 1'b0;
      data_in    = 8'hxx;
      check_frame(8'h55, 4);
      for (int k = 1; k < 5; k++) check_frame(vec[k], 0);
      check_idle("fifo_done");
    end
`else
    data_in    = 8'hA5;
    data_valid = 1'b1;
    step();
    check_frame(8'hA5, 0);
    check_idle("hold_gap");
    step();
    data_valid = 1'b0;
    data_in    = 8'hxx;
    check_frame(8'hA5, 0);
    check_idle("hold_done");
`endif

    push_byte(8'h2D);
    for (int k = 0; k < 4 * CBB + 2; k++) step();
    chk("mid_d3_busy", {7'd0, busy}, 8'd1);
    chk("mid_d3_tx",   {7'd0, tx},   8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx",   {7'd0, tx},         8'd1);
    chk("arst_busy", {7'd0, busy},       8'd0);
    chk("arst_rdy",  {7'd0, data_ready}, 8'd0);
    step();
    rst = 1'b0;
    step();
    check_idle("rel");
    push_byte(8'h3C);
    check_frame(8'h3C, 0);
    check_idle("after_3c");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
